scan_loader: RTL

Bitstream transmitter for the rotating-tile grid's scan chain and configuration latches. Accepts configuration bytes over a valid/ready stream, assembles each frame of `CHAIN_LEN` bits, and shifts it into the grid without gaps. It then pulses the grid's latch selector to commit vertical, horizontal and diagonal flip frames, and optionally returns the bits displaced from the chain. It sits between the host byte interface and the grid's `in_se`/`in_sc`/`in_cfg`/`out_sc` pins.

---
 rtl/scan_pkg.sv | 32 +++
 rtl/scan_loader_frame_buffer.sv | 35 +++
 rtl/scan_loader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types for the scan chain loader: FSM states, latch-select frame codes,
// and the frame-order helper (V, H, D, then the state-only frame).
package scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_UNLOAD,
        S_DONE
    } state_t;

    localparam logic [1:0] CFG_NONE = 2'd0;
    localparam logic [1:0] CFG_V    = 2'd1;
    localparam logic [1:0] CFG_H    = 2'd2;
    localparam logic [1:0] CFG_D    = 2'd3;

    // State-only frame maps to CFG_NONE, so it naturally sorts last.
    function automatic logic [1:0] next_frame(input logic [3:0] mask);
        if (mask[1])      return CFG_V;
        else if (mask[2]) return CFG_H;
        else if (mask[3]) return CFG_D;
        else              return CFG_NONE;
    endfunction

    // Mask bit index equals the frame code.
    function automatic logic [3:0] frame_bit(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

endpackage

// File: rtl/scan_loader_frame_buffer.sv
// CHAIN_LEN-bit frame register: byte-indexed load, 1-bit serial shift-right
// with serial input at the MSB, and shift-right-by-8 for readback.
module frame_buffer #(
    parameter int CHAIN_LEN = 64,
    localparam int NBYTES   = CHAIN_LEN / 8,
    localparam int IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load_en,
    input  logic [IDX_W-1:0]     i_load_idx,
    input  logic [7:0]           i_load_byte,
    input  logic                 i_shift_en,
    input  logic                 i_shift_in,
    input  logic                 i_shift8_en,
    output logic [CHAIN_LEN-1:0] o_buf
);

    logic [CHAIN_LEN-1:0] r_buf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf <= '0;
        end else if (i_load_en) begin
            r_buf[int'(i_load_idx)*8 +: 8] <= i_load_byte;
        end else if (i_shift_en) begin
            r_buf <= {i_shift_in, r_buf[CHAIN_LEN-1:1]};
        end else if (i_shift8_en) begin
            r_buf <= r_buf >> 8;
        end
    end

    assign o_buf = r_buf;

endmodule

// File: rtl/scan_loader.sv
// Scan chain bitstream loader: buffers a full frame, shifts it gap-free, pulses the
// latch selector per frame. Readback of displaced bits under SCAN_LOADER_READBACK_EN.
module scan_loader
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] frame_mask,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       busy,
    output logic       done,
    output logic       scan_se,
    output logic       scan_sc,
    output logic [1:0] scan_cfg,
    input  logic       scan_in
`ifdef SCAN_LOADER_READBACK_EN
    ,
    output logic [7:0] rb_data,
    output logic       rb_valid,
    input  logic       rb_ready
`endif
);

    localparam int NBYTES = CHAIN_LEN / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW     = $clog2(CHAIN_LEN);

    state_t               r_state, w_state_nxt, w_after_frame, w_next_load;
    logic [CW-1:0]        r_cnt;
    logic [1:0]           r_frame;
    logic [3:0]           r_mask;
    logic [CHAIN_LEN-1:0] w_buf;
    logic                 w_load_en, w_shift_en, w_shift8_en, w_cnt_clr, w_cnt_inc;
    logic [3:0]           w_src;
    logic [1:0]           w_code;
    logic                 w_shift_in;
    logic                 w_unused;

    assign w_next_load = (r_mask != 4'd0) ? S_LOAD : S_DONE;
    assign w_src       = (r_state == S_IDLE) ? frame_mask : r_mask;
    assign w_code      = next_frame(w_src);

`ifdef SCAN_LOADER_READBACK_EN
    assign w_after_frame = S_UNLOAD;
    assign w_shift_in    = scan_in;
    assign w_unused      = ^w_buf[CHAIN_LEN-1:1];
`else
    assign w_after_frame = w_next_load;
    assign w_shift_in    = 1'b0;
    assign w_unused      = ^{scan_in, w_buf[CHAIN_LEN-1:1]};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load_en   = 1'b0;
        w_shift_en  = 1'b0;
        w_shift8_en = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: if (start) begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = (frame_mask == 4'd0) ? S_DONE : S_LOAD;
            end
            S_LOAD: if (s_valid) begin
                w_load_en = 1'b1;
                if (r_cnt == CW'(NBYTES - 1)) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_SHIFT: begin
                w_shift_en = 1'b1;
                if (r_cnt == CW'(CHAIN_LEN - 1)) begin
                    w_cnt_clr   = 1'b1;
                    // State frame has no latch code; scan_se dropping is its commit.
                    w_state_nxt = (r_frame != CFG_NONE) ? S_LATCH : w_after_frame;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_LATCH: w_state_nxt = w_after_frame;
`ifdef SCAN_LOADER_READBACK_EN
            S_UNLOAD: if (rb_ready) begin
                w_shift8_en = 1'b1;
                if (r_cnt == CW'(NBYTES - 1)) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = w_next_load;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_frame <= CFG_NONE;
            r_mask  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
            // Every entry into LOAD consumes the next enabled frame from the mask.
            if (r_state != S_LOAD && w_state_nxt == S_LOAD) begin
                r_frame <= w_code;
                r_mask  <= w_src & ~frame_bit(w_code);
            end
        end
    end

    frame_buffer #(.CHAIN_LEN(CHAIN_LEN)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load_en   (w_load_en),
        .i_load_idx  (r_cnt[IDX_W-1:0]),
        .i_load_byte (s_data),
        .i_shift_en  (w_shift_en),
        .i_shift_in  (w_shift_in),
        .i_shift8_en (w_shift8_en),
        .o_buf       (w_buf)
    );

    assign s_ready  = (r_state == S_LOAD);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign scan_se  = (r_state == S_SHIFT);
    assign scan_sc  = scan_se & w_buf[0];
    assign scan_cfg = (r_state == S_LATCH) ? r_frame : CFG_NONE;

`ifdef SCAN_LOADER_READBACK_EN
    assign rb_valid = (r_state == S_UNLOAD);
    assign rb_data  = rb_valid ? w_buf[7:0] : 8'h00;
`endif

endmodule
